// File: rtl/march_bist_ctrl_pkg.sv
// Shared types and March C- element tables for the memory BIST sequencer.
package march_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         NUM_ELEMS = 6;
    localparam logic [2:0] LAST_ELEM = 3'd5;

    // Per-element tables, bit i belongs to element Ei.
    // Direction: 1 = descending (E3, E4).
    localparam logic [NUM_ELEMS-1:0] ELEM_DESC    = 6'b011000;
    // Two ops per address for E1..E4, one op for E0 and E5.
    localparam logic [NUM_ELEMS-1:0] ELEM_TWO_OPS = 6'b011110;
    // First op is a write only in E0; second op is always a write.
    localparam logic [NUM_ELEMS-1:0] OP0_WRITE    = 6'b000001;
    localparam logic [NUM_ELEMS-1:0] OP1_WRITE    = 6'b011110;
    // Data polarity (expected for reads, stored for writes).
    localparam logic [NUM_ELEMS-1:0] OP0_POL      = 6'b010100;
    localparam logic [NUM_ELEMS-1:0] OP1_POL      = 6'b001010;

    // Look up one element's bit in a table; out-of-range elements read as 0.
    function automatic logic elem_bit(input logic [NUM_ELEMS-1:0] tbl, input logic [2:0] elem);
        logic b;
        case (elem)
            3'd0:    b = tbl[0];
            3'd1:    b = tbl[1];
            3'd2:    b = tbl[2];
            3'd3:    b = tbl[3];
            3'd4:    b = tbl[4];
            3'd5:    b = tbl[5];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic op_is_write(input logic [2:0] elem, input logic op);
        return op ? elem_bit(OP1_WRITE, elem) : elem_bit(OP0_WRITE, elem);
    endfunction

    function automatic logic op_pol(input logic [2:0] elem, input logic op);
        return op ? elem_bit(OP1_POL, elem) : elem_bit(OP0_POL, elem);
    endfunction

endpackage

// File: rtl/march_bist_ctrl_if.sv
// Single-port memory bus between the BIST controller and the memory under test.
interface march_bist_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_write_read;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_write_read, output mem_address, output mem_wdata, input mem_rdata);
    modport slave  (input mem_write_read, input mem_address, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/march_bist_ctrl_cmp_pipe.sv
// Two-stage expected-data pipeline aligned to the memory's read latency,
// with mismatch detection, first-failure capture and a saturating fail counter.
module march_cmp_pipe
    import march_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push_valid,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [2:0]            push_elem,
    input  logic [DATA_WIDTH-1:0] push_exp,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH+3:0] fail_count
);

    localparam logic [ADDR_WIDTH+3:0] CNT_MAX = {(ADDR_WIDTH+4){1'b1}};
    localparam logic [ADDR_WIDTH+3:0] CNT_ONE = {{(ADDR_WIDTH+3){1'b0}}, 1'b1};

    logic                  s1_valid_q, s2_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
    logic [2:0]            s1_elem_q, s2_elem_q;
    logic [DATA_WIDTH-1:0] s1_exp_q, s2_exp_q;

    logic                  fail_d, fail_q;
    logic [ADDR_WIDTH-1:0] fail_addr_d, fail_addr_q;
    logic [2:0]            fail_elem_d, fail_elem_q;
    logic [DATA_WIDTH-1:0] fail_data_d, fail_data_q;
    logic [ADDR_WIDTH+3:0] fail_count_d, fail_count_q;
    logic                  mismatch_s;

    // Score the read whose data is on rdata now; keep only the first failure's details.
    always_comb begin
        mismatch_s   = s2_valid_q && (rdata != s2_exp_q);
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_data_d  = fail_data_q;
        fail_count_d = fail_count_q;
        if (clr) begin
            fail_d       = 1'b0;
            fail_addr_d  = {ADDR_WIDTH{1'b0}};
            fail_elem_d  = 3'd0;
            fail_data_d  = {DATA_WIDTH{1'b0}};
            fail_count_d = {(ADDR_WIDTH+4){1'b0}};
        end else if (mismatch_s) begin
            if (fail_count_q != CNT_MAX) begin
                fail_count_d = fail_count_q + CNT_ONE;
            end else begin
                fail_count_d = fail_count_q;
            end
            if (!fail_q) begin
                fail_d      = 1'b1;
                fail_addr_d = s2_addr_q;
                fail_elem_d = s2_elem_q;
                fail_data_d = rdata;
            end else begin
                fail_d = fail_q;
            end
        end else begin
            fail_d = fail_q;
        end
    end

    // Shift the compare pipeline every cycle and register the results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_addr_q    <= {ADDR_WIDTH{1'b0}};
            s2_addr_q    <= {ADDR_WIDTH{1'b0}};
            s1_elem_q    <= 3'd0;
            s2_elem_q    <= 3'd0;
            s1_exp_q     <= {DATA_WIDTH{1'b0}};
            s2_exp_q     <= {DATA_WIDTH{1'b0}};
            fail_q       <= 1'b0;
            fail_addr_q  <= {ADDR_WIDTH{1'b0}};
            fail_elem_q  <= 3'd0;
            fail_data_q  <= {DATA_WIDTH{1'b0}};
            fail_count_q <= {(ADDR_WIDTH+4){1'b0}};
        end else begin
            s1_valid_q   <= push_valid;
            s1_addr_q    <= push_addr;
            s1_elem_q    <= push_elem;
            s1_exp_q     <= push_exp;
            s2_valid_q   <= s1_valid_q;
            s2_addr_q    <= s1_addr_q;
            s2_elem_q    <= s1_elem_q;
            s2_exp_q     <= s1_exp_q;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_data_q  <= fail_data_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_elem  = fail_elem_q;
    assign fail_data  = fail_data_q;
    assign fail_count = fail_count_q;

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: walks the six elements one op per cycle and feeds
// the compare pipeline. A lookahead pointer (p_*) always names the op for the
// next cycle so both the op registers and the one-cycle-early write data stay registered.
module march_bist_ctrl
    import march_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH+3:0] fail_count,
    march_bist_ctrl_if.master     mem
);

    localparam logic [ADDR_WIDTH-1:0] CAP_A  = ADDR_WIDTH'(CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] ADDR_1 = ADDR_WIDTH'(1);

    state_e                state_d, state_q;
    logic [2:0]            p_elem_d, p_elem_q;
    logic [ADDR_WIDTH-1:0] p_addr_d, p_addr_q;
    logic                  p_op_d, p_op_q;
    logic                  last_d, last_q;
    logic                  drain_d, drain_q;
    logic                  wr_d, wr_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic                  rd_valid_d, rd_valid_q;
    logic [2:0]            op_elem_d, op_elem_q;
    logic                  op_exp_d, op_exp_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;

    logic                  p_two_s, p_desc_s, p_wr_s, p_pol_s, at_end_s, p_last_s;
    logic [2:0]            nx_elem_s;
    logic [ADDR_WIDTH-1:0] nx_addr_s;
    logic                  nx_op_s, nx_pol_s;
    logic                  load_s, accept_s;

    // Decode the lookahead op and work out the op that follows it.
    always_comb begin
        p_two_s   = elem_bit(ELEM_TWO_OPS, p_elem_q);
        p_desc_s  = elem_bit(ELEM_DESC, p_elem_q);
        p_wr_s    = op_is_write(p_elem_q, p_op_q);
        p_pol_s   = op_pol(p_elem_q, p_op_q);
        at_end_s  = p_desc_s ? (p_addr_q == {ADDR_WIDTH{1'b0}}) : (p_addr_q == CAP_A);
        nx_elem_s = p_elem_q;
        nx_addr_s = p_addr_q;
        nx_op_s   = 1'b0;
        if (p_two_s && !p_op_q) begin
            nx_op_s = 1'b1;
        end else if (at_end_s) begin
            nx_elem_s = p_elem_q + 3'd1;
            nx_addr_s = elem_bit(ELEM_DESC, nx_elem_s) ? CAP_A : {ADDR_WIDTH{1'b0}};
        end else if (p_desc_s) begin
            nx_addr_s = p_addr_q - ADDR_1;
        end else begin
            nx_addr_s = p_addr_q + ADDR_1;
        end
        p_last_s = (p_elem_q == LAST_ELEM) && at_end_s && !(p_two_s && !p_op_q);
        nx_pol_s = op_pol(nx_elem_s, nx_op_s);
    end

    // Sequencer FSM: next state, lookahead advance and next memory op.
    always_comb begin
        state_d    = state_q;
        p_elem_d   = p_elem_q;
        p_addr_d   = p_addr_q;
        p_op_d     = p_op_q;
        last_d     = last_q;
        drain_d    = 1'b0;
        wr_d       = 1'b0;
        addr_d     = {ADDR_WIDTH{1'b0}};
        wdata_d    = {DATA_WIDTH{1'b0}};
        rd_valid_d = 1'b0;
        op_elem_d  = op_elem_q;
        op_exp_d   = op_exp_q;
        load_s     = 1'b0;
        accept_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                last_d = 1'b0;
                if (start) begin
                    state_d  = ST_RUN;
                    accept_s = 1'b1;
                    load_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (last_q) begin
                    state_d  = ST_DRAIN;
                    last_d   = 1'b0;
                    p_elem_d = 3'd0;
                    p_addr_d = {ADDR_WIDTH{1'b0}};
                    p_op_d   = 1'b0;
                end else begin
                    load_s = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_s) begin
            wr_d       = p_wr_s;
            addr_d     = p_addr_q;
            wdata_d    = {DATA_WIDTH{nx_pol_s}};
            rd_valid_d = !p_wr_s;
            op_elem_d  = p_elem_q;
            op_exp_d   = p_pol_s;
            p_elem_d   = nx_elem_s;
            p_addr_d   = nx_addr_s;
            p_op_d     = nx_op_s;
            last_d     = p_last_s;
        end else begin
            rd_valid_d = 1'b0;
        end
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_q == ST_DRAIN);
        done_d = (state_q == ST_DONE) && !start;
    end

    // State, lookahead pointer and registered memory/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            p_elem_q   <= 3'd0;
            p_addr_q   <= {ADDR_WIDTH{1'b0}};
            p_op_q     <= 1'b0;
            last_q     <= 1'b0;
            drain_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
            op_elem_q  <= 3'd0;
            op_exp_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_elem_q   <= p_elem_d;
            p_addr_q   <= p_addr_d;
            p_op_q     <= p_op_d;
            last_q     <= last_d;
            drain_q    <= drain_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= rd_valid_d;
            op_elem_q  <= op_elem_d;
            op_exp_q   <= op_exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem.mem_write_read = wr_q;
    assign mem.mem_address    = addr_q;
    assign mem.mem_wdata      = wdata_q;
    assign busy               = busy_q;
    assign done               = done_q;

    march_cmp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept_s),
        .push_valid (rd_valid_q),
        .push_addr  (addr_q),
        .push_elem  (op_elem_q),
        .push_exp   ({DATA_WIDTH{op_exp_q}}),
        .rdata      (mem.mem_rdata),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_data  (fail_data),
        .fail_count (fail_count)
    );

endmodule
